alu_pipe_fu: RTL and testbench
==============================

Name: alu_pipe_fu

Overview:
- Parametrised, pipelined integer ALU functional unit for the OoO execute stage.
- Takes issued ops (opa, opb, ALU_FUNC, destination physical tag, branch mask) and computes the result in the entry stage.
- Carries the result through STAGES elastic registers with valid/ready backpressure toward the CDB/complete arbiter.
- Supports branch-mispredict squash and branch-resolve mask clearing on in-flight ops.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 32.
- STAGES, 2, pipeline registers between accept and output (1..4); latency in cycles.
- TAG_W, 6, physical register tag width.
- BMASK_W, 4, branch mask width (one bit per unresolved branch).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  issue presents an op.
- in_ready  out  1  unit can accept this cycle.
- in_opa  in  XLEN  operand A.
- in_opb  in  XLEN  operand B.
- in_func  in  ALU_FUNC  operation select.
- in_tag  in  TAG_W  destination physical tag.
- in_bmask  in  BMASK_W  branches this op depends on.
- squash_valid  in  1  mispredict broadcast.
- squash_mask  in  BMASK_W  one-hot mispredicted branch.
- resolve_valid  in  1  correct-prediction broadcast.
- resolve_mask  in  BMASK_W  one-hot resolved branch.
- out_valid  out  1  completed op available.
- out_ready  in  1  downstream accepts.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  destination tag.
- out_bmask  out  BMASK_W  current branch mask of output op.

Behaviour:
- Reset (async, reset_n=0): all stage valids=0, so out_valid=0. out_result, out_tag and out_bmask read 0. Reset mid-operation discards all in-flight ops; no output after release until new accepts.
- Ops:
  - ADD/SUB/AND/OR/XOR: XLEN wrap-around arithmetic.
  - SLT: signed compare; SLTU: unsigned compare. Both zero-extend a 1-bit result.
  - SLL/SRL/SRA: shift amount = opb[$clog2(XLEN)-1:0]; SRA sign-fills.
  - Any other func code: result = 32'hfacebeec zero-extended to XLEN.
- Compute is combinational on in_* and is captured into stage 0 on accept (in_valid && in_ready).
- Elastic pipeline: stage i advances when valid[i] && ready[i+1].
  - ready[i] = !valid[i] || ready[i+1].
  - ready[STAGES] = out_ready.
  - in_ready = ready[0].
- No bubbles under continuous flow: throughput 1 op/cycle, latency STAGES cycles (accept at edge N gives out_valid after edge N+STAGES-1, i.e. visible in cycle N+STAGES) when out_ready held high.
- Stall (out_ready=0): the last stage holds and upstream fills; in_ready drops once all stages are valid. Held output values stay stable.
- Squash (squash_valid=1):
  - Every valid stage with (bmask & squash_mask) != 0 is invalidated at the next edge.
  - out_valid is masked combinationally in the squash cycle if the output op matches, so it is never consumed.
  - An incoming op that matches is dropped: in_ready is unaffected, but nothing is captured.
  - Non-matching ops proceed normally; freed slots refill the following cycle.
- Resolve (resolve_valid=1): the resolve_mask bit is cleared in all stage masks and in the captured in_bmask at the edge. out_bmask shows the cleared value combinationally in that same cycle.
- Simultaneous squash and resolve of different bits: both apply. The same bit in both is illegal; squash wins.
- Accept, advance and squash in the same cycle: squash is evaluated on each op's pre-clear mask, in whichever stage it enters.

Test Plan:
1. Reset/idle: assert reset_n=0 mid-stream with 2 ops in flight -> out_valid=0 immediately, in_ready=1 after release, no stale output.
2. Function sweep, XLEN=32, STAGES=2:
   - ADD 0xFFFFFFFF+1 -> 0x0; SUB 0-1 -> 0xFFFFFFFF.
   - SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
   - SRA 0x80000000 by opb=0x21 -> 0xC0000000 (shift 1).
   - Unknown func -> 0xfacebeec.
   - Each result appears 2 cycles after accept with the matching tag.
3. Throughput/backpressure: 8 back-to-back ADDs tagged 1..8; hold out_ready=0 for 3 cycles at op 3 -> in_ready falls after the pipe fills; all 8 emerge in order, none lost or duplicated.
4. Squash: ops A(bmask 0001), B(0010), C(0000) in flight; squash_mask=0010 -> B never has out_valid; A and C complete in order.
5. Resolve: op with bmask 0011 in stage 0; resolve_mask=0001 -> out_bmask=0010 at output; a later squash 0001 does not kill it.
6. Corner: an incoming op with bmask 0100 accepted in the same cycle as squash 0100 -> never output; XLEN=64 SLL by 63 of 1 -> 0x8000000000000000.

Source files
------------

// File: rtl/alu_pipe_fu.sv
// -----------------------------------------------------------------------------
// alu_pipe_fu_pkg
//   Operation encoding shared by the ALU functional unit and anything that
//   issues to it. Codes 10..15 are unassigned and return a marker value.
// -----------------------------------------------------------------------------
package alu_pipe_fu_pkg;

  localparam int unsigned FUNC_W = 4;

  typedef enum logic [FUNC_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_func_e;

  // Result returned for any unassigned function code (zero-extended to XLEN).
  localparam logic [31:0] UNKNOWN_RESULT = 32'hfacebeec;

endpackage : alu_pipe_fu_pkg

// -----------------------------------------------------------------------------
// alu_pipe_fu
//   Pipelined integer ALU functional unit for the out-of-order execute stage.
//   The result is computed combinationally from the issue inputs and captured
//   into stage 0 on accept; it then travels through STAGES elastic registers
//   with valid/ready flow control toward the completion arbiter. In-flight ops
//   carry a branch mask: a mispredict squash kills every op depending on the
//   squashed branch, a correct-prediction resolve clears that branch's bit.
//
// Ports
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready       issue handshake
//   in_opa, in_opb            operands (XLEN)
//   in_func                   operation select (alu_func_e encoding)
//   in_tag                    destination physical register tag
//   in_bmask                  unresolved branches the op depends on
//   squash_valid/_mask        one-hot mispredicted branch broadcast
//   resolve_valid/_mask       one-hot correctly predicted branch broadcast
//   out_valid / out_ready     completion handshake
//   out_result, out_tag       completed op result and destination tag
//   out_bmask                 branch mask of the output op (resolve applied)
// -----------------------------------------------------------------------------
module alu_pipe_fu
  import alu_pipe_fu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned BMASK_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,

  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_opa,
  input  logic [XLEN-1:0]    in_opb,
  input  logic [FUNC_W-1:0]  in_func,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [BMASK_W-1:0] in_bmask,

  input  logic               squash_valid,
  input  logic [BMASK_W-1:0] squash_mask,
  input  logic               resolve_valid,
  input  logic [BMASK_W-1:0] resolve_mask,

  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic [BMASK_W-1:0] out_bmask
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  // One pipeline slot: everything an op needs once its result is known.
  typedef struct packed {
    logic [XLEN-1:0]    result;
    logic [TAG_W-1:0]   tag;
    logic [BMASK_W-1:0] bmask;
  } slot_t;

  // ---------------------------------------------------------------------------
  // Combinational ALU on the issue inputs
  // ---------------------------------------------------------------------------
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;

  assign shamt = in_opb[SHAMT_W-1:0];

  // NOTE: every variable written in an always_comb gets a value before any
  // branch; a path that leaves it unassigned would infer a latch.
  always_comb begin
    alu_res = XLEN'(UNKNOWN_RESULT);
    case (in_func)
      ALU_ADD:  alu_res = in_opa + in_opb;
      ALU_SUB:  alu_res = in_opa - in_opb;
      ALU_AND:  alu_res = in_opa & in_opb;
      ALU_OR:   alu_res = in_opa | in_opb;
      ALU_XOR:  alu_res = in_opa ^ in_opb;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_opa) < $signed(in_opb))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_opa < in_opb)};
      ALU_SLL:  alu_res = in_opa << shamt;
      ALU_SRL:  alu_res = in_opa >> shamt;
      ALU_SRA:  alu_res = $signed(in_opa) >>> shamt;
      default:  alu_res = XLEN'(UNKNOWN_RESULT);
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] valid_q, valid_d;
  slot_t             slot_q [STAGES];
  slot_t             slot_d [STAGES];

  logic [STAGES-1:0] ready;
  logic [STAGES-1:0] up_valid;
  slot_t             up_slot [STAGES];

  logic [BMASK_W-1:0] kill_mask;
  logic [BMASK_W-1:0] clear_mask;

  assign kill_mask  = squash_valid  ? squash_mask  : '0;
  assign clear_mask = resolve_valid ? resolve_mask : '0;

  // ready[i] = !valid[i] || ready[i+1], with ready[STAGES] = out_ready,
  // unrolled: stage i is blocked only when it and every stage after it hold
  // an op and the consumer is stalled. A squash does not free a slot for
  // the same cycle; freed slots refill on the next one.
  for (genvar g = 0; g < STAGES; g++) begin : g_ready
    assign ready[g] = out_ready || !(&valid_q[STAGES-1:g]);
  end

  assign in_ready = ready[0];

  // What each stage would load if it advances: stage 0 takes the issue port,
  // every later stage takes the stage in front of it.
  always_comb begin
    up_valid[0]       = in_valid;
    up_slot[0].result = alu_res;
    up_slot[0].tag    = in_tag;
    up_slot[0].bmask  = in_bmask;
    for (int i = 1; i < STAGES; i++) begin
      up_valid[i] = valid_q[i-1];
      up_slot[i]  = slot_q[i-1];
    end
  end

  // Next state per stage. Squash is tested on the mask an op carries into
  // this edge (before the resolve clear), wherever the op lands; the resolve
  // clear is then applied to whatever the stage holds after the edge.
  always_comb begin
    valid_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      slot_d[i]  = slot_q[i];
      valid_d[i] = valid_q[i] && !(|(slot_q[i].bmask & kill_mask));
      if (ready[i]) begin
        valid_d[i] = up_valid[i] && !(|(up_slot[i].bmask & kill_mask));
        if (up_valid[i]) begin
          slot_d[i] = up_slot[i];
        end
      end
      slot_d[i].bmask = slot_d[i].bmask & ~clear_mask;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would let stages shoot through.
  // NOTE: the slot arrays are reset along with the valids so the outputs read
  // zero out of reset; they are a handful of flops, not a RAM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < STAGES; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // An output op hit by this cycle's squash is hidden immediately so the
  // consumer can never take it; the stage itself is cleared at the edge.
  assign out_valid  = valid_q[STAGES-1] && !(|(slot_q[STAGES-1].bmask & kill_mask));
  assign out_result = slot_q[STAGES-1].result;
  assign out_tag    = slot_q[STAGES-1].tag;
  assign out_bmask  = slot_q[STAGES-1].bmask & ~clear_mask;

endmodule : alu_pipe_fu

// File: tb/tb_alu_pipe_fu.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe_fu
//   Bench for alu_pipe_fu. A 32-bit/2-stage instance gets directed scenarios
//   plus randomized traffic checked by an in-order scoreboard; a 64-bit/
//   3-stage instance gets directed wide-shift and latency checks.
// -----------------------------------------------------------------------------
module tb_alu_pipe_fu;
  import alu_pipe_fu_pkg::*;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic        clock;
  logic        reset_n;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_opa, in_opb;
  logic [3:0]  in_func;
  logic [5:0]  in_tag;
  logic [3:0]  in_bmask;
  logic        squash_valid, resolve_valid;
  logic [3:0]  squash_mask, resolve_mask;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_tag;
  logic [3:0]  out_bmask;

  logic        w_in_valid, w_in_ready;
  logic [63:0] w_in_opa, w_in_opb;
  logic [3:0]  w_in_func;
  logic [5:0]  w_in_tag;
  logic [3:0]  w_in_bmask;
  logic        w_squash_valid, w_resolve_valid;
  logic [3:0]  w_squash_mask, w_resolve_mask;
  logic        w_out_valid, w_out_ready;
  logic [63:0] w_out_result;
  logic [5:0]  w_out_tag;
  logic [3:0]  w_out_bmask;

  alu_pipe_fu #(.XLEN(32), .STAGES(2), .TAG_W(6), .BMASK_W(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opa(in_opa), .in_opb(in_opb), .in_func(in_func),
    .in_tag(in_tag), .in_bmask(in_bmask),
    .squash_valid(squash_valid), .squash_mask(squash_mask),
    .resolve_valid(resolve_valid), .resolve_mask(resolve_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_bmask(out_bmask)
  );

  alu_pipe_fu #(.XLEN(64), .STAGES(3), .TAG_W(6), .BMASK_W(4)) dut64 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_opa(w_in_opa), .in_opb(w_in_opb), .in_func(w_in_func),
    .in_tag(w_in_tag), .in_bmask(w_in_bmask),
    .squash_valid(w_squash_valid), .squash_mask(w_squash_mask),
    .resolve_valid(w_resolve_valid), .resolve_mask(w_resolve_mask),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_result(w_out_result), .out_tag(w_out_tag), .out_bmask(w_out_bmask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU: plain arithmetic on 64-bit values, masked to xlen.
  function automatic logic [63:0] ref_alu(input int xlen, input logic [3:0] f,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    longint      sa, sb;
    int          sh;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (xlen == 32) begin
      sa = longint'(signed'(a[31:0]));
      sb = longint'(signed'(b[31:0]));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    sh = int'(b[31:0]) & (xlen - 1);
    case (f)
      ALU_ADD:  return (a + b) & mask;
      ALU_SUB:  return (a - b) & mask;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return (sa < sb) ? 64'd1 : 64'd0;
      ALU_SLTU: return (a < b) ? 64'd1 : 64'd0;
      ALU_SLL:  return (a << sh) & mask;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return 64'(sa >>> sh) & mask;
      default:  return 64'h0000_0000_FACE_BEEC;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard for the 32-bit instance: an in-order list of ops that should
  // still emerge. Sampled on the falling edge; each pass applies the effects
  // of the following rising edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    logic [3:0]  bm;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_keep[$];
  exp_t       mon_e;
  logic [3:0] mon_clr;
  logic [5:0] fired_tags[$];
  int         accept_cnt = 0;
  int         fire_cnt   = 0;
  logic       saw_full   = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      mon_clr = resolve_valid ? resolve_mask : 4'b0;
      if (!in_ready) saw_full = 1'b1;
      if (out_valid && out_ready) begin
        fire_cnt++;
        fired_tags.push_back(out_tag);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_result", 64'(out_result), 64'(mon_e.res));
          check("sb_tag", 64'(out_tag), 64'(mon_e.tag));
          check("sb_bmask", 64'(out_bmask), 64'(mon_e.bm & ~mon_clr));
          check("sb_squashed_out", 64'(squash_valid && ((mon_e.bm & squash_mask) != 4'b0)), 64'd0);
        end
      end
      mon_keep.delete();
      foreach (exp_q[k]) begin
        mon_e = exp_q[k];
        if (!(squash_valid && ((mon_e.bm & squash_mask) != 4'b0))) begin
          mon_e.bm = mon_e.bm & ~mon_clr;
          mon_keep.push_back(mon_e);
        end
      end
      exp_q = mon_keep;
      if (in_valid && in_ready) begin
        accept_cnt++;
        if (!(squash_valid && ((in_bmask & squash_mask) != 4'b0))) begin
          mon_e.res = 32'(ref_alu(32, in_func, 64'(in_opa), 64'(in_opb)));
          mon_e.tag = in_tag;
          mon_e.bm  = in_bmask & ~mon_clr;
          exp_q.push_back(mon_e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input logic [3:0] bm, output int waits);
    logic acc;
    in_valid = 1'b1;
    in_func  = f;
    in_opa   = a;
    in_opb   = b;
    in_tag   = tag;
    in_bmask = bm;
    acc      = 1'b0;
    waits    = 0;
    while (!acc && waits < 200) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      waits++;
    end
    in_valid = 1'b0;
    if (!acc) check("issue_timeout", 64'd0, 64'd1);
  endtask

  // Issue one op into an empty pipe and check the 2-cycle latency and value.
  task automatic dir_op(input string name, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] tag, input logic [31:0] exp);
    int w;
    issue(f, a, b, tag, 4'b0, w);
    check({name, "_early"}, 64'(out_valid), 64'd0);
    cyc();
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_result"}, 64'(out_result), 64'(exp));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    cyc();
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // 64-bit directed vectors: SLL 1 by 63, SRA sign fill with opb high bits
  // ignored, unknown function code.
  logic [3:0]  w_f[3]   = '{4'd7, 4'd9, 4'd12};
  logic [63:0] w_a[3]   = '{64'd1, 64'h8000_0000_0000_0000, 64'd5};
  logic [63:0] w_b[3]   = '{64'd63, 64'h44, 64'd6};
  logic [63:0] w_exp[3] = '{64'h8000_0000_0000_0000, 64'hF800_0000_0000_0000,
                            64'h0000_0000_FACE_BEEC};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int w;
    int base;
    int fire0;
    int s;
    int r;

    reset_n = 1'b0;
    in_valid = 1'b0; in_opa = '0; in_opb = '0; in_func = '0; in_tag = '0; in_bmask = '0;
    squash_valid = 1'b0; squash_mask = '0; resolve_valid = 1'b0; resolve_mask = '0;
    out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_opa = '0; w_in_opb = '0; w_in_func = '0; w_in_tag = '0;
    w_in_bmask = '0; w_squash_valid = 1'b0; w_squash_mask = '0; w_resolve_valid = 1'b0;
    w_resolve_mask = '0; w_out_ready = 1'b1;

    repeat (3) cyc();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_bmask", 64'(out_bmask), 64'd0);
    reset_n = 1'b1;
    cyc();
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Reset with two ops in flight.
    issue(ALU_ADD, 32'd1, 32'd2, 6'd40, 4'b0, w);
    issue(ALU_ADD, 32'd3, 32'd4, 6'd41, 4'b0, w);
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_result", 64'(out_result), 64'd0);
    cyc();
    cyc();
    reset_n = 1'b1;
    #1;
    check("mid_rel_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("mid_no_stale", 64'(out_valid), 64'd0);
    end

    // Function sweep with 2-cycle latency.
    dir_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 6'd1, 32'h0);
    dir_op("sub_wrap", ALU_SUB, 32'd0, 32'd1, 6'd2, 32'hFFFF_FFFF);
    dir_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 6'd3, 32'd1);
    dir_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 6'd4, 32'd0);
    dir_op("sra", ALU_SRA, 32'h8000_0000, 32'h21, 6'd5, 32'hC000_0000);
    dir_op("srl", ALU_SRL, 32'h8000_0000, 32'd31, 6'd6, 32'd1);
    dir_op("sll_amt32", ALU_SLL, 32'h1234_5678, 32'h20, 6'd7, 32'h1234_5678);
    dir_op("xor", ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 6'd8, 32'h0FF0_0FF0);
    dir_op("unknown", 4'hF, 32'd1, 32'd2, 6'd9, 32'hFACE_BEEC);

    // No bubbles under continuous flow.
    for (int t = 0; t < 4; t++) begin
      issue(ALU_OR, $urandom, $urandom, 6'(50 + t), 4'b0, w);
      check("nobubble_accept_cycles", 64'(w), 64'd1);
    end
    repeat (4) cyc();

    // Throughput with a 3-cycle output stall at op 3.
    base = accept_cnt;
    fire0 = fire_cnt;
    fired_tags.delete();
    saw_full = 1'b0;
    fork
      begin
        for (int t = 1; t <= 8; t++) issue(ALU_ADD, $urandom, $urandom, 6'(t), 4'b0, w);
      end
      begin
        int n;
        n = 0;
        while (accept_cnt < base + 3 && n < 100) begin
          cyc();
          n++;
        end
        out_ready = 1'b0;
        repeat (3) cyc();
        out_ready = 1'b1;
      end
    join
    repeat (6) cyc();
    check("tp_in_ready_fell", 64'(saw_full), 64'd1);
    check("tp_count", 64'(fire_cnt - fire0), 64'd8);
    for (int t = 0; t < 8; t++) begin
      if (t < fired_tags.size()) check("tp_order", 64'(fired_tags[t]), 64'(t + 1));
      else check("tp_missing", 64'd0, 64'd1);
    end

    // Squash of the middle op of three.
    fired_tags.delete();
    out_ready = 1'b0;
    issue(ALU_ADD, 32'd10, 32'd0, 6'd10, 4'b0001, w);
    issue(ALU_ADD, 32'd11, 32'd0, 6'd11, 4'b0010, w);
    in_valid = 1'b1; in_func = ALU_ADD; in_opa = 32'd12; in_opb = 32'd0;
    in_tag = 6'd12; in_bmask = 4'b0000;
    squash_valid = 1'b1; squash_mask = 4'b0010;
    cyc();
    squash_valid = 1'b0; squash_mask = 4'b0;
    out_ready = 1'b1;
    issue(ALU_ADD, 32'd12, 32'd0, 6'd12, 4'b0000, w);
    repeat (6) cyc();
    check("sq_count", 64'(fired_tags.size()), 64'd2);
    if (fired_tags.size() == 2) begin
      check("sq_first", 64'(fired_tags[0]), 64'd10);
      check("sq_second", 64'(fired_tags[1]), 64'd12);
    end

    // Resolve in stage 0, then a squash of the resolved bit must not kill it.
    fired_tags.delete();
    out_ready = 1'b0;
    issue(ALU_SUB, 32'd100, 32'd1, 6'd20, 4'b0011, w);
    resolve_valid = 1'b1; resolve_mask = 4'b0001;
    cyc();
    resolve_valid = 1'b0; resolve_mask = 4'b0;
    squash_valid = 1'b1; squash_mask = 4'b0001;
    cyc();
    squash_valid = 1'b0; squash_mask = 4'b0;
    check("res_valid", 64'(out_valid), 64'd1);
    check("res_bmask", 64'(out_bmask), 64'b0010);
    check("res_tag", 64'(out_tag), 64'd20);
    resolve_valid = 1'b1; resolve_mask = 4'b0010;
    #1;
    check("res_comb_bmask", 64'(out_bmask), 64'b0000);
    cyc();
    resolve_valid = 1'b0; resolve_mask = 4'b0;
    check("res_held_bmask", 64'(out_bmask), 64'b0000);
    check("res_held_result", 64'(out_result), 64'd99);
    out_ready = 1'b1;
    repeat (3) cyc();
    check("res_emerged", 64'(fired_tags.size()), 64'd1);

    // Squash of a stalled output op hides it in the same cycle.
    out_ready = 1'b0;
    issue(ALU_AND, 32'hFF, 32'h0F, 6'd21, 4'b1000, w);
    cyc();
    check("sqout_pre", 64'(out_valid), 64'd1);
    squash_valid = 1'b1; squash_mask = 4'b1000;
    #1;
    check("sqout_masked", 64'(out_valid), 64'd0);
    cyc();
    squash_valid = 1'b0; squash_mask = 4'b0;
    check("sqout_gone", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    cyc();

    // Incoming op squashed in its accept cycle.
    fire0 = fire_cnt;
    in_valid = 1'b1; in_func = ALU_ADD; in_opa = 32'd7; in_opb = 32'd7;
    in_tag = 6'd30; in_bmask = 4'b0100;
    squash_valid = 1'b1; squash_mask = 4'b0100;
    #1;
    check("corner_in_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    squash_valid = 1'b0; squash_mask = 4'b0;
    repeat (5) cyc();
    check("corner_dropped", 64'(fire_cnt - fire0), 64'd0);

    // 64-bit / 3-stage instance.
    for (int i = 0; i < 3; i++) begin
      w_in_valid = 1'b1; w_in_func = w_f[i]; w_in_opa = w_a[i]; w_in_opb = w_b[i];
      w_in_tag = 6'(i + 5); w_in_bmask = 4'b0;
      #1;
      check("w_in_ready", 64'(w_in_ready), 64'd1);
      cyc();
      w_in_valid = 1'b0;
      check("w_lat_edge0", 64'(w_out_valid), 64'd0);
      cyc();
      check("w_lat_edge1", 64'(w_out_valid), 64'd0);
      cyc();
      check("w_valid", 64'(w_out_valid), 64'd1);
      check("w_result", w_out_result, w_exp[i]);
      check("w_tag", 64'(w_out_tag), 64'(i + 5));
      cyc();
    end

    // Randomized traffic against the scoreboard.
    fire0 = fire_cnt;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_func  = ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 11));
      in_opa   = pick32();
      in_opb   = pick32();
      in_tag   = 6'($urandom);
      in_bmask = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      s = $urandom_range(0, 3);
      r = (s + $urandom_range(1, 3)) % 4;
      squash_valid  = ($urandom_range(0, 9) == 0);
      squash_mask   = 4'b0001 << s;
      resolve_valid = ($urandom_range(0, 7) == 0);
      resolve_mask  = 4'b0001 << r;
      cyc();
    end
    in_valid = 1'b0;
    squash_valid = 1'b0;
    resolve_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) cyc();
    check("rand_progress", 64'(fire_cnt > fire0 + 50), 64'd1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_idle", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_pipe_fu
